// File: rtl/regfile_port_ctrl_pkg.sv
// Shared constants and the write-buffer entry type for the register-file port controller.
// Operand and address widths live here so the interface, FIFO and top always agree.
package regfile_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 32;
    localparam int WB_DEPTH_DEF = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Decode, execute, write-back and register-file signals of the operand port.
// The master modport is the controller; the slave modport is its surroundings.
interface regfile_port_ctrl_if;
    import regfile_pkg::*;

    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_rs;
    logic [ADDR_W-1:0] dec_rt;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [ADDR_W-1:0] rf_addr1;
    logic [ADDR_W-1:0] rf_addr2;
    logic [DATA_W-1:0] rf_out1;
    logic [DATA_W-1:0] rf_out2;
    logic              rf_rw;
    logic [ADDR_W-1:0] rf_addr3;
    logic [DATA_W-1:0] rf_data3;

    modport master (
        input  dec_valid, dec_rs, dec_rt,
        output dec_ready,
        output ex_valid, ex_op1, ex_op2,
        input  ex_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output rf_addr1, rf_addr2,
        input  rf_out1, rf_out2,
        output rf_rw, rf_addr3, rf_data3
    );

    modport slave (
        output dec_valid, dec_rs, dec_rt,
        input  dec_ready,
        input  ex_valid, ex_op1, ex_op2,
        output ex_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  rf_addr1, rf_addr2,
        output rf_out1, rf_out2,
        input  rf_rw, rf_addr3, rf_data3
    );

endinterface

// File: rtl/regfile_port_ctrl_wb_fifo.sv
// Circular write-back buffer with an oldest-first view of its live entries, so the
// controller can forward the youngest matching write to either read port.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  wb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    input  logic [ADDR_W-1:0]             match_addr1_i,
    input  logic [ADDR_W-1:0]             match_addr2_i,
    output wb_entry_t                     head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0][DATA_W-1:0]  age_data_o,
    output logic [DEPTH-1:0]              match1_o,
    output logic [DEPTH-1:0]              match2_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count says they are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Walk from the head so index 0 is the oldest entry and higher indices are younger.
    always_comb begin : age_view
        logic [PTR_W-1:0] idx;
        idx        = rd_ptr_q;
        age_data_o = '0;
        match1_o   = '0;
        match2_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_data_o[i] = mem_q[idx].data;
            if (CNT_W'(i) < count_q) begin
                match1_o[i] = (mem_q[idx].addr == match_addr1_i);
                match2_o[i] = (mem_q[idx].addr == match_addr2_i);
            end
            idx = ptr_inc(idx);
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Operand-fetch and write-back port controller in front of a 2-read/1-write register file.
// Registers operands for execute, buffers write-backs and forwards every pending write.
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_port_ctrl_if.master  bus
);

    logic                           ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]              ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0]              ex_op2_q, ex_op2_d;
    logic                           rf_rw_q;
    wb_entry_t                      drain_q;

    logic                           dec_fire;
    logic                           wb_fire;
    logic                           fifo_full;
    logic                           fifo_empty;
    wb_entry_t                      fifo_head;
    wb_entry_t                      wb_entry;
    logic [WB_DEPTH-1:0][DATA_W-1:0] fifo_age_data;
    logic [WB_DEPTH-1:0]            fifo_match1;
    logic [WB_DEPTH-1:0]            fifo_match2;
    logic [DATA_W-1:0]              fwd_op1;
    logic [DATA_W-1:0]              fwd_op2;

    assign bus.dec_ready = !reset && (!ex_valid_q || bus.ex_ready);
    assign bus.wb_ready  = !reset && !fifo_full;
    assign dec_fire      = bus.dec_valid && bus.dec_ready;
    assign wb_fire       = bus.wb_valid && bus.wb_ready;

    assign bus.rf_addr1  = bus.dec_rs;
    assign bus.rf_addr2  = bus.dec_rt;

    assign wb_entry.addr = bus.wb_addr;
    assign wb_entry.data = bus.wb_data;

    wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (wb_fire),
        .push_entry_i  (wb_entry),
        .pop_i         (!fifo_empty),
        .match_addr1_i (bus.dec_rs),
        .match_addr2_i (bus.dec_rt),
        .head_o        (fifo_head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .age_data_o    (fifo_age_data),
        .match1_o      (fifo_match1),
        .match2_o      (fifo_match2)
    );

    // Lowest priority first so later assignments win: regfile, drain, older..younger buffer, incoming write.
    always_comb begin
        fwd_op1 = bus.rf_out1;
        fwd_op2 = bus.rf_out2;
        if (rf_rw_q && (drain_q.addr == bus.dec_rs)) fwd_op1 = drain_q.data;
        if (rf_rw_q && (drain_q.addr == bus.dec_rt)) fwd_op2 = drain_q.data;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (fifo_match1[i]) fwd_op1 = fifo_age_data[i];
            if (fifo_match2[i]) fwd_op2 = fifo_age_data[i];
        end
        if (wb_fire && (bus.wb_addr == bus.dec_rs)) fwd_op1 = bus.wb_data;
        if (wb_fire && (bus.wb_addr == bus.dec_rt)) fwd_op2 = bus.wb_data;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        if (dec_fire) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = fwd_op1;
            ex_op2_d   = fwd_op2;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
        end
    end

    // The drain register keeps its last address/data after the pulse; only rf_rw marks a live write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_rw_q <= 1'b0;
            drain_q <= '0;
        end else if (!fifo_empty) begin
            rf_rw_q <= 1'b1;
            drain_q <= fifo_head;
        end else begin
            rf_rw_q <= 1'b0;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op1   = ex_op1_q;
    assign bus.ex_op2   = ex_op2_q;
    assign bus.rf_rw    = rf_rw_q;
    assign bus.rf_addr3 = drain_q.addr;
    assign bus.rf_data3 = drain_q.data;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl: a vector table for the operand/forwarding path plus
// hand-written sequences for write ordering, back-pressure, full buffer, reset and r0 forwarding.
module tb_regfile_port_ctrl;
    import regfile_pkg::*;

    typedef struct {
        logic              decValid;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              exReady;
        logic              wbValid;
        logic [ADDR_W-1:0] wbAddr;
        logic [DATA_W-1:0] wbData;
        logic              expExValid;
        logic [DATA_W-1:0] expOp1;
        logic [DATA_W-1:0] expOp2;
        logic              expRfRw;
        logic [ADDR_W-1:0] expAddr3;
        logic [DATA_W-1:0] expData3;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic rfInit;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [DATA_W-1:0] regs [NUM_REGS];
    int                wrCount = 0;
    logic [ADDR_W-1:0] wrAddrLog [64];
    logic [DATA_W-1:0] wrDataLog [64];

    regfile_port_ctrl_if bus ();
    regfile_port_ctrl_if bus1 ();

    regfile_port_ctrl #(.WB_DEPTH(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
    regfile_port_ctrl #(.WB_DEPTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    // Register file seen by the main instance: combinational read, write on the clock edge.
    assign bus.rf_out1  = regs[bus.rf_addr1];
    assign bus.rf_out2  = regs[bus.rf_addr2];
    assign bus1.rf_out1 = '0;
    assign bus1.rf_out2 = '0;

    always @(posedge clk) begin
        if (rfInit) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            regs[3] <= 32'd6;
            regs[5] <= 32'h20;
        end else if (bus.rf_rw) begin
            regs[bus.rf_addr3] <= bus.rf_data3;
            if (wrCount < 64) begin
                wrAddrLog[wrCount] <= bus.rf_addr3;
                wrDataLog[wrCount] <= bus.rf_data3;
            end
            wrCount <= wrCount + 1;
        end
    end

    function automatic vec_t mkVec(
        input logic dv, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt, input logic er,
        input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
        input logic ev, input logic [DATA_W-1:0] o1, input logic [DATA_W-1:0] o2,
        input logic rw, input logic [ADDR_W-1:0] a3, input logic [DATA_W-1:0] d3);
        vec_t v;
        v.decValid = dv; v.rs = rs; v.rt = rt; v.exReady = er;
        v.wbValid = wv; v.wbAddr = wa; v.wbData = wd;
        v.expExValid = ev; v.expOp1 = o1; v.expOp2 = o2;
        v.expRfRw = rw; v.expAddr3 = a3; v.expData3 = d3;
        return v;
    endfunction

    task automatic setInputs(
        input logic dv, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt, input logic er,
        input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        bus.dec_valid = dv;
        bus.dec_rs    = rs;
        bus.dec_rt    = rt;
        bus.ex_ready  = er;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRegs(input string tag, input logic ev, input logic [DATA_W-1:0] o1,
                             input logic [DATA_W-1:0] o2, input logic rw,
                             input logic [ADDR_W-1:0] a3, input logic [DATA_W-1:0] d3);
        checkOutput({tag, " ex_valid"}, DATA_W'(bus.ex_valid), DATA_W'(ev));
        checkOutput({tag, " ex_op1"},   bus.ex_op1, o1);
        checkOutput({tag, " ex_op2"},   bus.ex_op2, o2);
        checkOutput({tag, " rf_rw"},    DATA_W'(bus.rf_rw), DATA_W'(rw));
        checkOutput({tag, " rf_addr3"}, DATA_W'(bus.rf_addr3), DATA_W'(a3));
        checkOutput({tag, " rf_data3"}, bus.rf_data3, d3);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        setInputs(v.decValid, v.rs, v.rt, v.exReady, v.wbValid, v.wbAddr, v.wbData);
        tick();
        checkRegs($sformatf("vec%0d", idx), v.expExValid, v.expOp1, v.expOp2,
                  v.expRfRw, v.expAddr3, v.expData3);
    endtask

    initial begin
        vec_t vecs [8];
        int   base;

        // basic read, incoming-write forwarding, drain pulse, buffer and drain-register forwarding
        vecs[0] = mkVec(1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 32'd6,   32'h20, 1'b0, 5'd0, 32'h0);
        vecs[1] = mkVec(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 32'hAB,  1'b1, 32'hAB,  32'd6,  1'b0, 5'd0, 32'h0);
        vecs[2] = mkVec(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 32'hAB,  32'd6,  1'b1, 5'd7, 32'hAB);
        vecs[3] = mkVec(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,   1'b0, 32'hAB,  32'd6,  1'b0, 5'd7, 32'hAB);
        vecs[4] = mkVec(1'b1, 5'd7, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 32'hAB,  32'h20, 1'b0, 5'd7, 32'hAB);
        vecs[5] = mkVec(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 32'h55,  1'b1, 32'h0,   32'h0,  1'b0, 5'd7, 32'hAB);
        vecs[6] = mkVec(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 32'h55,  32'h55, 1'b1, 5'd9, 32'h55);
        vecs[7] = mkVec(1'b1, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,   1'b1, 32'h55,  32'd6,  1'b0, 5'd9, 32'h55);

        reset  = 1'b1;
        rfInit = 1'b1;
        setInputs(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        bus1.dec_valid = 1'b0; bus1.dec_rs = '0; bus1.dec_rt = '0; bus1.ex_ready = 1'b1;
        bus1.wb_valid  = 1'b0; bus1.wb_addr = '0; bus1.wb_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset dec_ready", DATA_W'(bus.dec_ready), 32'd0);
        checkOutput("reset wb_ready",  DATA_W'(bus.wb_ready),  32'd0);
        tick();
        checkRegs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        rfInit = 1'b0;
        #1;
        checkOutput("post-reset dec_ready", DATA_W'(bus.dec_ready), 32'd1);
        checkOutput("post-reset wb_ready",  DATA_W'(bus.wb_ready),  32'd1);

        for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

        // same-address writes on consecutive cycles: youngest forwarded, committed in order
        base = wrCount;
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'd1); tick();
        checkOutput("t3 no early drain", DATA_W'(bus.rf_rw), 32'd0);
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'd2); tick();
        checkOutput("t3 first drain data", bus.rf_data3, 32'd1);
        @(negedge clk); setInputs(1'b1, 5'd4, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkOutput("t3 op1 youngest", bus.ex_op1, 32'd2);
        checkOutput("t3 op2 youngest", bus.ex_op2, 32'd2);
        checkOutput("t3 second drain data", bus.rf_data3, 32'd2);
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkOutput("t3 drain idle", DATA_W'(bus.rf_rw), 32'd0);
        checkOutput("t3 write count", DATA_W'(wrCount - base), 32'd2);
        checkOutput("t3 write0 addr", DATA_W'(wrAddrLog[base]), 32'd4);
        checkOutput("t3 write0 data", wrDataLog[base], 32'd1);
        checkOutput("t3 write1 data", wrDataLog[base + 1], 32'd2);

        // execute stalled while write-backs stream through the buffer
        @(negedge clk); setInputs(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd10, 32'h100); tick();
        checkRegs("t4 capture", 1'b1, 32'd6, 32'h20, 1'b0, 5'd4, 32'd2);
        @(negedge clk); setInputs(1'b1, 5'd5, 5'd3, 1'b0, 1'b1, 5'd11, 32'h101); #1;
        checkOutput("t4 dec_ready stalled", DATA_W'(bus.dec_ready), 32'd0);
        checkOutput("t4 wb_ready second", DATA_W'(bus.wb_ready), 32'd1);
        tick();
        checkRegs("t4 hold1", 1'b1, 32'd6, 32'h20, 1'b1, 5'd10, 32'h100);
        @(negedge clk); setInputs(1'b1, 5'd5, 5'd3, 1'b0, 1'b1, 5'd12, 32'h102); #1;
        checkOutput("t4 wb_ready third", DATA_W'(bus.wb_ready), 32'd1);
        tick();
        checkRegs("t4 hold2", 1'b1, 32'd6, 32'h20, 1'b1, 5'd11, 32'h101);
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkRegs("t4 release", 1'b0, 32'd6, 32'h20, 1'b1, 5'd12, 32'h102);
        @(negedge clk); tick();
        checkOutput("t4 drain idle", DATA_W'(bus.rf_rw), 32'd0);

        // single-entry buffer: full blocks the next write, which is not passed through
        @(negedge clk); bus1.wb_valid = 1'b1; bus1.wb_addr = 5'd1; bus1.wb_data = 32'd5; #1;
        checkOutput("t4 depth1 ready empty", DATA_W'(bus1.wb_ready), 32'd1);
        tick();
        @(negedge clk); bus1.wb_addr = 5'd2; bus1.wb_data = 32'd6; #1;
        checkOutput("t4 depth1 full", DATA_W'(bus1.wb_ready), 32'd0);
        tick();
        checkOutput("t4 depth1 drain addr", DATA_W'(bus1.rf_addr3), 32'd1);
        @(negedge clk); #1;
        checkOutput("t4 depth1 slot freed", DATA_W'(bus1.wb_ready), 32'd1);
        tick();
        checkOutput("t4 depth1 no pass-through", DATA_W'(bus1.rf_rw), 32'd0);
        @(negedge clk); bus1.wb_valid = 1'b0; tick();
        checkOutput("t4 depth1 late drain rw", DATA_W'(bus1.rf_rw), 32'd1);
        checkOutput("t4 depth1 late drain data", bus1.rf_data3, 32'd6);

        // reset with one write draining and one buffered: the buffered one is lost
        @(negedge clk); setInputs(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd13, 32'h77); tick();
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd14, 32'h88); tick();
        checkOutput("t5 drain before reset", DATA_W'(bus.rf_addr3), 32'd13);
        @(negedge clk); reset = 1'b1; setInputs(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0); #1;
        checkOutput("t5 dec_ready in reset", DATA_W'(bus.dec_ready), 32'd0);
        checkOutput("t5 wb_ready in reset",  DATA_W'(bus.wb_ready),  32'd0);
        tick();
        checkRegs("t5 reset", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        base = wrCount;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t5 no drain %0d", i), DATA_W'(bus.rf_rw), 32'd0);
        end
        checkOutput("t5 no further writes", DATA_W'(wrCount - base), 32'd0);
        @(negedge clk); setInputs(1'b1, 5'd14, 5'd13, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkOutput("t5 discarded r14", bus.ex_op1, 32'h0);
        checkOutput("t5 committed r13", bus.ex_op2, 32'h77);

        // r0 is an ordinary register: forwarded from the drain register and from an incoming write
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'd9); tick();
        @(negedge clk); setInputs(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkOutput("t6 drain r0 rw", DATA_W'(bus.rf_rw), 32'd1);
        checkOutput("t6 drain r0 data", bus.rf_data3, 32'd9);
        @(negedge clk); setInputs(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        checkOutput("t6 op1 r0", bus.ex_op1, 32'd9);
        checkOutput("t6 op2 r0", bus.ex_op2, 32'd9);
        @(negedge clk); setInputs(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 32'h22); tick();
        checkOutput("t6 incoming beats regfile", bus.ex_op1, 32'h22);
        checkOutput("t6 other port regfile", bus.ex_op2, 32'd6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
